// File: rtl/br_router_pkg.sv
// Package br_router_pkg
//   Shared types and helpers for the AXI B-channel response router and its
//   round-robin arbiter.
//   - resp_e       : AXI BRESP encoding
//   - slot_state_e : occupancy of the single registered output slot
//   - idx_w        : index width for an N-entry vector (minimum 1 bit)
//   - rr_next      : round-robin successor of an index modulo N
//   - is_err_resp  : true for SLVERR/DECERR
//   The slot record itself depends on ID_W/DST_W, so it is declared inside
//   the router next to those parameters.
package br_router_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // BRESP[1] distinguishes the two error codes from the two OK codes.
    function automatic logic is_err_resp(input logic [1:0] r);
        return r[1];
    endfunction

endpackage

// File: rtl/axi_b_resp_router_if.sv
// Interface axi_b_resp_router_if
//   Bundles the B-channel signals around the router.
//   M_AXI_* : NUM_SRC downstream sources (packed, source i at [i*W +: W])
//   S_AXI_* : NUM_DST upstream destinations (bid/bresp shared, bvalid one-hot)
//   Modports:
//     slave  - the router side (consumes M_AXI_b*, produces S_AXI_b*)
//     master - the environment side (drives sources and destination readies)
interface axi_b_resp_router_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_DST = 2,
    parameter int ID_W    = 2
);
    logic [NUM_SRC*ID_W-1:0] M_AXI_bid;
    logic [NUM_SRC*2-1:0]    M_AXI_bresp;
    logic [NUM_SRC-1:0]      M_AXI_bvalid;
    logic [NUM_SRC-1:0]      M_AXI_bready;
    logic [ID_W-1:0]         S_AXI_bid;
    logic [1:0]              S_AXI_bresp;
    logic [NUM_DST-1:0]      S_AXI_bvalid;
    logic [NUM_DST-1:0]      S_AXI_bready;

    modport slave (
        input  M_AXI_bid, M_AXI_bresp, M_AXI_bvalid, S_AXI_bready,
        output M_AXI_bready, S_AXI_bid, S_AXI_bresp, S_AXI_bvalid
    );

    modport master (
        output M_AXI_bid, M_AXI_bresp, M_AXI_bvalid, S_AXI_bready,
        input  M_AXI_bready, S_AXI_bid, S_AXI_bresp, S_AXI_bvalid
    );
endinterface

// File: rtl/br_rr_arbiter.sv
// Module br_rr_arbiter
//   Purely combinational round-robin arbiter. Searches req starting at ptr
//   and wrapping around; the first requester found wins.
//   Ports:
//     req   in  N      request vector
//     ptr   in  IDX_W  highest-priority index (0..N-1)
//     grant out N      one-hot grant (all zero when no request)
//     idx   out IDX_W  index of the granted requester (0 when none)
//     any   out 1      at least one request present
//   With N=1 this collapses to grant = req.
module br_rr_arbiter
    import br_router_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found_s;

    // Rotating priority search: first active request at or after ptr wins.
    always_comb begin
        int cand;
        grant   = {N{1'b0}};
        idx     = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found_s && req[cand]) begin
                found_s     = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axi_b_resp_router.sv
// Module axi_b_resp_router
//   AXI4 write-response router: NUM_SRC downstream B sources are arbitrated
//   round-robin into one registered output slot, which presents the held
//   response to the destination decoded from the low DST_W bits of BID.
//   Sustains one response per cycle (slot drains and refills in one cycle).
//   Ports:
//     ACLK, ARESETN   clock, asynchronous active-low reset
//     bus (slave)     M_AXI_b* sources in, S_AXI_b* destinations out
//     drop_err        sticky flag: a response with out-of-range BID was sunk
//     err_cnt         saturating count of SLVERR/DECERR responses delivered
//     last_err_bid    BID of the most recent error response delivered
//   Build option: define BR_ERR_LOG_EN to enable err_cnt/last_err_bid;
//   otherwise both are tied to zero and no counting logic exists.
module axi_b_resp_router
    import br_router_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_DST = 2,
    parameter int ID_W    = 2,
    parameter int DST_W   = idx_w(NUM_DST)
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    axi_b_resp_router_if.slave bus,
    output logic               drop_err,
    output logic [15:0]        err_cnt,
    output logic [ID_W-1:0]    last_err_bid
);

    localparam int SRC_W = idx_w(NUM_SRC);

    typedef struct packed {
        logic [ID_W-1:0]  bid;
        resp_e            bresp;
        logic [DST_W-1:0] dst;
    } slot_t;

    slot_state_e        state_q, state_d;
    slot_t              slot_q, slot_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic               drop_err_q, drop_err_d;
    logic [NUM_DST-1:0] s_bvalid_q, s_bvalid_d;

    logic [NUM_SRC-1:0] grant_s;
    logic [SRC_W-1:0]   win_s;
    logic               any_req_s;
    logic [ID_W-1:0]    win_bid_s;
    logic [1:0]         win_resp_s;
    logic [DST_W-1:0]   win_dst_s;
    logic               in_range_s;
    logic               drain_s;
    logic               accept_ok_s;
    logic               m_hs_s;
    logic               capture_s;

    br_rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .req   (bus.M_AXI_bvalid),
        .ptr   (ptr_q),
        .grant (grant_s),
        .idx   (win_s),
        .any   (any_req_s)
    );

    assign win_bid_s  = bus.M_AXI_bid[win_s*ID_W +: ID_W];
    assign win_resp_s = bus.M_AXI_bresp[win_s*2 +: 2];
    assign win_dst_s  = win_bid_s[DST_W-1:0];
    assign in_range_s = (int'(win_dst_s) < NUM_DST);

    // s_bvalid_q is one-hot on the held destination exactly while FULL,
    // so masking it with the ready vector gives the drain condition.
    assign drain_s     = (state_q == FULL) && (|(s_bvalid_q & bus.S_AXI_bready));
    // Reset gating keeps BREADY low while ARESETN is asserted.
    assign accept_ok_s = ARESETN && ((state_q == EMPTY) || drain_s);
    assign m_hs_s      = accept_ok_s && any_req_s;
    assign capture_s   = m_hs_s && in_range_s;

    // Source-side ready: only the arbitration winner, only when the slot can take it.
    always_comb begin
        bus.M_AXI_bready = grant_s & {NUM_SRC{accept_ok_s}};
    end

    // Slot occupancy FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (capture_s) state_d = FULL;
                else           state_d = EMPTY;
            end
            FULL: begin
                if (capture_s)    state_d = FULL;
                else if (drain_s) state_d = EMPTY;
                else              state_d = FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Slot contents, rr pointer and drop flag; a drop still consumes the grant.
    always_comb begin
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        drop_err_d = drop_err_q;
        if (m_hs_s) begin
            ptr_d = SRC_W'(rr_next(int'(win_s), NUM_SRC));
            if (in_range_s) begin
                slot_d.bid   = win_bid_s;
                slot_d.bresp = resp_e'(win_resp_s);
                slot_d.dst   = win_dst_s;
            end else begin
                drop_err_d = 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Registered one-hot destination valid derived from the next slot state.
    always_comb begin
        s_bvalid_d = {NUM_DST{1'b0}};
        if (state_d == FULL) begin
            for (int d = 0; d < NUM_DST; d++) begin
                s_bvalid_d[d] = (slot_d.dst == DST_W'(d));
            end
        end else begin
            s_bvalid_d = {NUM_DST{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= EMPTY;
            slot_q     <= '{bid: {ID_W{1'b0}}, bresp: OKAY, dst: {DST_W{1'b0}}};
            ptr_q      <= {SRC_W{1'b0}};
            drop_err_q <= 1'b0;
            s_bvalid_q <= {NUM_DST{1'b0}};
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            ptr_q      <= ptr_d;
            drop_err_q <= drop_err_d;
            s_bvalid_q <= s_bvalid_d;
        end
    end

    assign bus.S_AXI_bid    = slot_q.bid;
    assign bus.S_AXI_bresp  = slot_q.bresp;
    assign bus.S_AXI_bvalid = s_bvalid_q;
    assign drop_err         = drop_err_q;

`ifdef BR_ERR_LOG_EN
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [ID_W-1:0] last_err_bid_q, last_err_bid_d;

    // Log error responses that enter the slot; dropped responses are not counted.
    always_comb begin
        err_cnt_d      = err_cnt_q;
        last_err_bid_d = last_err_bid_q;
        if (capture_s && is_err_resp(win_resp_s)) begin
            if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 16'd1;
            else                          err_cnt_d = err_cnt_q;
            last_err_bid_d = win_bid_s;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error log registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_cnt_q      <= 16'h0000;
            last_err_bid_q <= {ID_W{1'b0}};
        end else begin
            err_cnt_q      <= err_cnt_d;
            last_err_bid_q <= last_err_bid_d;
        end
    end

    assign err_cnt      = err_cnt_q;
    assign last_err_bid = last_err_bid_q;
`else
    assign err_cnt      = 16'h0000;
    assign last_err_bid = {ID_W{1'b0}};
`endif

endmodule
